// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one instruction-memory request at a
// time, buffers the returned word for decode and applies branch/jump redirects.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_instr_o,
    output logic [6:0]  out_instr_type_o,
    output logic        fetch_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        kill_q, kill_d;
    logic        halt_pend_q, halt_pend_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        fetch_err_q, fetch_err_d;
    logic        redir_ok_s;
    logic        redir_bad_s;

    assign redir_ok_s  = redirect_valid_i && (redirect_pc_i[1:0] == 2'b00);
    assign redir_bad_s = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);

    // State register and datapath registers, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            kill_q      <= 1'b0;
            halt_pend_q <= 1'b0;
            out_pc_q    <= RESET_PC;
            out_instr_q <= NOP_INSTR;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            kill_q      <= kill_d;
            halt_pend_q <= halt_pend_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // Next-state logic: fetch sequencing, redirect handling and stale-response discard.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        kill_d      = kill_q;
        halt_pend_d = halt_pend_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        fetch_err_d = fetch_err_q;

        case (state_q)
            ST_IDLE: begin
                state_d    = ST_FETCH;
                req_addr_d = pc_q;
            end
            ST_FETCH: begin
                // The request address never moves until the response arrives.
                if (redir_bad_s) begin
                    fetch_err_d = 1'b1;
                    if (imem_rvalid_i) begin
                        state_d = ST_HALT;
                    end else begin
                        kill_d      = 1'b1;
                        halt_pend_d = 1'b1;
                    end
                end else if (redir_ok_s) begin
                    pc_d = redirect_pc_i;
                    if (imem_rvalid_i) begin
                        req_addr_d = redirect_pc_i;
                        kill_d     = 1'b0;
                        if (halt_pend_q) begin
                            state_d = ST_HALT;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid_i) begin
                    if (kill_q) begin
                        kill_d = 1'b0;
                        if (halt_pend_q) begin
                            state_d = ST_HALT;
                        end else begin
                            req_addr_d = pc_q;
                        end
                    end else begin
                        out_pc_d    = req_addr_q;
                        out_instr_d = imem_rdata_i;
                        pc_d        = req_addr_q + 32'd4;
                        state_d     = ST_HOLD;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                // A redirect wins over the handshake; any handshake this cycle still completes.
                if (redir_bad_s) begin
                    fetch_err_d = 1'b1;
                    state_d     = ST_HALT;
                end else if (redir_ok_s) begin
                    pc_d       = redirect_pc_i;
                    req_addr_d = redirect_pc_i;
                    state_d    = ST_FETCH;
                end else if (out_ready_i) begin
                    req_addr_d = pc_q;
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_req_o       = (state_q == ST_FETCH);
    assign imem_addr_o      = req_addr_q;
    assign out_valid_o      = (state_q == ST_HOLD);
    assign out_pc_o         = out_pc_q;
    assign out_instr_o      = out_instr_q;
    assign out_instr_type_o = out_instr_q[6:0];
    assign fetch_err_o      = fetch_err_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the single-cycle RISC-V core, directly upstream of decode and immediate generation. It owns the program counter and issues one word request at a time to instruction memory. It buffers the returned word and presents the word, its PC and its opcode field (`instr_type`, bits [6:0]) to the consumer over a valid/ready handshake. It also accepts PC redirects from the branch/jump unit and discards any in-flight fetch that a redirect makes stale.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC of the first fetch after reset.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `imem_req` out 1: fetch request; held high until `imem_rvalid`.
- `imem_addr` out 32: fetch word address; stable while `imem_req` is high.
- `imem_rvalid` in 1: response valid; only meaningful while `imem_req` is high.
- `imem_rdata` in 32: instruction word, sampled when `imem_req && imem_rvalid`.
- `redirect_valid` in 1: one-cycle PC redirect pulse (taken branch, JAL, JALR).
- `redirect_pc` in 32: redirect target.
- `out_valid` out 1: buffered instruction available.
- `out_ready` in 1: consumer accepts when `out_valid && out_ready`.
- `out_pc` out 32: PC of the buffered instruction.
- `out_instr` out 32: buffered instruction word.
- `out_instr_type` out 7: equals `out_instr[6:0]`.
- `fetch_err` out 1: sticky; set on a misaligned redirect.

## Operation
- Registers:
  - `pc` is the next fetch PC.
  - `req_addr` drives `imem_addr`.
  - `kill` marks the in-flight response for discard.
  - `halt_pend` is set by a misaligned redirect that arrives mid-fetch.
  - The output buffer holds `out_pc`, `out_instr` and `out_valid`.
- States:
  - IDLE: `imem_req`=0 and `out_valid`=0. IDLE lasts exactly one cycle after reset, then the block goes to FETCH with `req_addr`=`pc`.
  - FETCH: `imem_req`=1. On `imem_rvalid` with `kill`=0 and no redirect in the same cycle:
    - load the buffer from `req_addr` and `imem_rdata`;
    - set `pc`=`req_addr`+4, mod 2^32;
    - go to HOLD.
  - HOLD: `out_valid`=1 and `imem_req`=0. On handshake: `req_addr`=`pc`, `out_valid`=0, go to FETCH.
  - HALT: `imem_req`=0, `out_valid`=0, `fetch_err`=1. HALT is left only by `rst`.
- A memory transaction is never abandoned. Once `imem_req` rises it stays high, with the same address, until `imem_rvalid`.
- Aligned redirect (`redirect_pc[1:0]`==0):
  - In HOLD, with or without a handshake in the same cycle: the handshake, if any, completes. Then `pc`=`req_addr`=`redirect_pc`, `out_valid`=0, go to FETCH.
  - In FETCH with `imem_rvalid` in the same cycle: drop the data and leave the buffer untouched. Set `req_addr`=`pc`=`redirect_pc` and stay in FETCH, so the request continues at the new address next cycle.
  - In FETCH without `imem_rvalid`: set `pc`=`redirect_pc` and `kill`=1, and keep `req_addr`. When the response arrives, drop it, clear `kill`, and set `req_addr`=`pc`.
  - In IDLE or HALT: ignored.
  - If several redirects arrive while `kill`=1, the last one wins.
- Misaligned redirect (`redirect_pc[1:0]`!=0):
  - `fetch_err` is set on the next edge.
  - In HOLD, or in FETCH with `imem_rvalid` in the same cycle: go to HALT.
  - In FETCH without `imem_rvalid`: set `kill`=1 and `halt_pend`=1. When the response arrives, discard it and go to HALT.
- A killed response never reaches the output buffer.
- Buffer outputs are stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `out_valid`=0, `out_pc`=`RESET_PC`.
  - `out_instr`=32'h0000_0013 (NOP), `out_instr_type`=7'b0010011.
  - `fetch_err`=0, `kill`=0, `halt_pend`=0, state IDLE.
- `rst` mid-transaction returns the block to IDLE immediately. The pending response is not tracked; the memory must be reset together with the block.
- First `imem_req` is in the second cycle after `rst` falls.
- With zero-wait memory (`imem_rvalid` in the same cycle as `imem_req`), `out_valid` rises one edge later. The steady-state throughput is one instruction per 2 cycles with `out_ready` held high.
- A redirect takes effect on `imem_addr` the cycle after it is sampled, or the cycle after the pending response if `kill` is set.
- All outputs are registered or decoded from state only. There is no combinational path from `out_ready`, `redirect_*` or `imem_*` to any output.

## Test plan
- Reset with `RESET_PC`=0 and zero-wait memory returning addr^32'hA5A5_0000, `out_ready`=1 → `out_pc` sequence 0,4,8,C, each with the matching `out_instr`; `out_instr_type`=`out_instr[6:0]`.
- 3-cycle memory latency and `out_ready` low for 5 cycles in HOLD → `imem_addr` stable for 3 cycles; `out_*` stable for 5 cycles; next fetch at `out_pc`+4.
- Redirect to 32'h100 while a 3-cycle fetch of 0x8 is pending → `imem_addr` stays 0x8 until `imem_rvalid`; the 0x8 word is never presented; the next request is at 0x100 and `out_pc`=0x100.
- Redirect to 0x40 in HOLD in the same cycle as a handshake of PC 0x10 → the 0x10 instruction is consumed once; the next `out_pc`=0x40.
- Fetch at 32'hFFFF_FFFC → next `imem_addr`=0x0 (wrap).
- Redirect to 0x102 with a fetch pending → `fetch_err`=1 next cycle; `imem_req` stays high until `imem_rvalid`, then both `imem_req` and `out_valid` stay 0 until `rst`; after `rst` the first fetch is at `RESET_PC` with `fetch_err`=0.
